// File: rtl/switch_alloc_rr.sv
// switch_alloc_rr: per-output round-robin switch allocator with wormhole packet locking
module switch_alloc_rr #(
  parameter int NPORTS   = 5,
  parameter int DATASIZE = 40,
  parameter int WORMHOLE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NPORTS-1:0]          in_valid,
  input  logic [NPORTS*NPORTS-1:0]   in_req,
  input  logic [NPORTS*DATASIZE-1:0] in_data,
  input  logic [NPORTS-1:0]          out_full,
  output logic [NPORTS-1:0]          in_ready,
  output logic [NPORTS-1:0]          out_valid,
  output logic [NPORTS*DATASIZE-1:0] out_data,
  output logic [NPORTS*NPORTS-1:0]   out_grant,
  output logic                       req_err
);
  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [1:0] FT_HEAD = 2'b01;
  localparam logic [1:0] FT_TAIL = 2'b10;
  logic [NPORTS-1:0] req_ok, req_bad;
  logic err_q, err_d;
  for (genvar i = 0; i < NPORTS; i++) begin : g_in
    logic [NPORTS-1:0] slice, col;
    logic onehot;
    assign slice = in_req[i*NPORTS +: NPORTS];
    assign onehot = (|slice) && !(|(slice & (slice - 1'b1)));
    assign req_ok[i] = in_valid[i] && onehot;
    assign req_bad[i] = in_valid[i] && !onehot;
    // gather this input's grant bit from every output
    always_comb begin
      col = '0;
      for (int o = 0; o < NPORTS; o++) col[o] = out_grant[o*NPORTS+i];
    end
    assign in_ready[i] = !in_valid[i] || (|col);
  end
  for (genvar o = 0; o < NPORTS; o++) begin : g_out
    logic [NPORTS-1:0] req, gnt;
    logic hit, lock_q, lock_d, v_q, v_d;
    logic [IW-1:0] win, cand, ptr_q, ptr_d, lid_q, lid_d;
    logic [DATASIZE-1:0] win_flit, d_q, d_d;
    logic [1:0] ftype;
    // requesters of this output: valid inputs with a clean one-hot request for o
    always_comb begin
      req = '0;
      for (int i = 0; i < NPORTS; i++) req[i] = req_ok[i] && in_req[i*NPORTS+o];
    end
    // locked: only the packet owner may pass; unlocked: first requester at or after ptr
    always_comb begin
      hit = 1'b0;
      win = '0;
      cand = '0;
      if (!out_full[o] && lock_q) begin
        hit = req[lid_q];
        win = lid_q;
      end else if (!out_full[o]) begin
        for (int k = 0; k < NPORTS; k++) begin
          cand = IW'((int'(ptr_q) + k) % NPORTS);
          if (!hit && req[cand]) begin
            hit = 1'b1;
            win = cand;
          end
        end
      end
    end
    // one-hot grant vector and the winning flit
    always_comb begin
      gnt = '0;
      win_flit = '0;
      for (int i = 0; i < NPORTS; i++) begin
        gnt[i] = hit && (win == IW'(i));
        if (gnt[i]) win_flit = in_data[i*DATASIZE +: DATASIZE];
      end
    end
    assign ftype = win_flit[1:0];
    // pointer advances past the winner; head locks, tail unlocks; outputs hold while full
    always_comb begin
      ptr_d = hit ? ((win == IW'(NPORTS-1)) ? '0 : win + 1'b1) : ptr_q;
      lock_d = (WORMHOLE != 0) && (hit ? (lock_q ? (ftype != FT_TAIL) : (ftype == FT_HEAD)) : lock_q);
      lid_d = (hit && !lock_q) ? win : lid_q;
      v_d = out_full[o] ? v_q : hit;
      d_d = hit ? win_flit : d_q;
    end
    // per-output state with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ptr_q <= '0;
        lid_q <= '0;
        lock_q <= 1'b0;
        v_q <= 1'b0;
        d_q <= '0;
      end else begin
        ptr_q <= ptr_d;
        lid_q <= lid_d;
        lock_q <= lock_d;
        v_q <= v_d;
        d_q <= d_d;
      end
    end
    assign out_grant[o*NPORTS +: NPORTS] = gnt;
    assign out_valid[o] = v_q;
    assign out_data[o*DATASIZE +: DATASIZE] = d_q;
  end
  // sticky flag for malformed requests from valid inputs
  always_comb err_d = err_q || (|req_bad);
  // error flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else err_q <= err_d;
  end
  assign req_err = err_q;
endmodule

// File: tb/tb_switch_alloc_rr.sv
// tb_switch_alloc_rr: directed table and sequence checks for switch_alloc_rr
module tb_switch_alloc_rr;
  localparam logic [2:0] NONE = 3'd7;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] in_valid, out_full, in_ready, out_valid;
  logic [24:0] in_req, out_grant;
  logic [199:0] in_data, out_data;
  logic req_err;
  int n_chk = 0;
  int n_fail = 0;
  int seq = 0;
  typedef struct {
    logic [4:0] v;
    logic [14:0] dst;
    logic [9:0] ft;
    logic [4:0] full;
    logic [14:0] win;
    logic [4:0] rdy;
    logic [4:0] ov;
  } vec_t;
  vec_t tbl[8];
  logic [24:0] eg;
  logic [2:0] w;

  switch_alloc_rr dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_req(in_req), .in_data(in_data),
    .out_full(out_full), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_grant(out_grant), .req_err(req_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [39:0] flit(input int src, input int n, input logic [1:0] t);
    return {8'(src), 30'(n), t};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] v, input logic [14:0] dst, input logic [9:0] ft, input logic [4:0] full);
    in_valid = v;
    out_full = full;
    in_req = '0;
    in_data = '0;
    for (int i = 0; i < 5; i++) begin
      in_req[i*5 + int'(dst[i*3 +: 3])] = 1'b1;
      in_data[i*40 +: 40] = flit(i, seq, ft[i*2 +: 2]);
    end
  endtask

  task automatic reset_pulse(input string nm);
    @(negedge clk);
    drive(5'b0, '0, '0, 5'b0);
    rst = 1'b1;
    #1;
    chk({nm, " rst out_valid"}, 64'(out_valid), 64'd0);
    chk({nm, " rst out_data"}, 64'(|out_data), 64'd0);
    chk({nm, " rst req_err"}, 64'(req_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{v:5'b00010, dst:{3'd0,3'd0,3'd0,3'd4,3'd0}, ft:10'h3FF, full:5'b0, win:{3'd1,NONE,NONE,NONE,NONE}, rdy:5'b11111, ov:5'b10000};
    tbl[1] = '{v:5'b00100, dst:{3'd0,3'd0,3'd4,3'd0,3'd0}, ft:10'h3FF, full:5'b0, win:{3'd2,NONE,NONE,NONE,NONE}, rdy:5'b11111, ov:5'b10000};
    tbl[2] = '{v:5'b01000, dst:{3'd0,3'd4,3'd0,3'd0,3'd0}, ft:10'h3FF, full:5'b0, win:{3'd3,NONE,NONE,NONE,NONE}, rdy:5'b11111, ov:5'b10000};
    tbl[3] = '{v:5'b10001, dst:{3'd4,3'd0,3'd0,3'd0,3'd4}, ft:10'h3FF, full:5'b0, win:{3'd4,NONE,NONE,NONE,NONE}, rdy:5'b11110, ov:5'b10000};
    tbl[4] = '{v:5'b10001, dst:{3'd4,3'd0,3'd0,3'd0,3'd4}, ft:10'h3FF, full:5'b0, win:{3'd0,NONE,NONE,NONE,NONE}, rdy:5'b01111, ov:5'b10000};
    tbl[5] = '{v:5'b11111, dst:{3'd0,3'd1,3'd2,3'd3,3'd4}, ft:10'h3FF, full:5'b0, win:{3'd0,3'd1,3'd2,3'd3,3'd4}, rdy:5'b11111, ov:5'b11111};
    tbl[6] = '{v:5'b01100, dst:{3'd0,3'd3,3'd2,3'd0,3'd0}, ft:10'h3FF, full:5'b0, win:{NONE,3'd3,3'd2,NONE,NONE}, rdy:5'b11111, ov:5'b01100};
    tbl[7] = '{v:5'b00010, dst:{3'd0,3'd0,3'd0,3'd2,3'd0}, ft:10'h3FF, full:5'b00100, win:{NONE,NONE,NONE,NONE,NONE}, rdy:5'b11101, ov:5'b00100};
    rst = 1'b1;
    drive(5'b0, '0, '0, 5'b0);
    @(posedge clk);
    @(negedge clk);
    chk("init out_valid", 64'(out_valid), 64'd0);
    chk("init out_data", 64'(|out_data), 64'd0);
    chk("init req_err", 64'(req_err), 64'd0);
    rst = 1'b0;
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      seq = r;
      drive(tbl[r].v, tbl[r].dst, tbl[r].ft, tbl[r].full);
      eg = '0;
      for (int o = 0; o < 5; o++) begin
        w = tbl[r].win[o*3 +: 3];
        if (w != NONE) eg[o*5 + int'(w)] = 1'b1;
      end
      #1;
      chk($sformatf("row%0d out_grant", r), 64'(out_grant), 64'(eg));
      chk($sformatf("row%0d in_ready", r), 64'(in_ready), 64'(tbl[r].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d out_valid", r), 64'(out_valid), 64'(tbl[r].ov));
      for (int o = 0; o < 5; o++) begin
        w = tbl[r].win[o*3 +: 3];
        if (w != NONE)
          chk($sformatf("row%0d out_data%0d", r, o), 64'(out_data[o*40 +: 40]), 64'(flit(int'(w), r, tbl[r].ft[int'(w)*2 +: 2])));
      end
    end
    chk("full hold data2", 64'(out_data[80 +: 40]), 64'(flit(2, 6, 2'b11)));
    reset_pulse("A");
    // wormhole packet from input 2 to output 1 with input 3 contending, stalled by out_full
    @(negedge clk); seq = 100;
    drive(5'b01100, {3'd0,3'd1,3'd1,3'd0,3'd0}, {2'b00,2'b11,2'b01,2'b00,2'b00}, 5'b0);
    #1;
    chk("A head grant", 64'(out_grant[5 +: 5]), 64'b00100);
    chk("A head ready", 64'(in_ready), 64'b10111);
    @(posedge clk); #1;
    chk("A head valid", 64'(out_valid[1]), 64'd1);
    chk("A head data", 64'(out_data[40 +: 40]), 64'(flit(2, 100, 2'b01)));
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); seq = 101 + c;
      drive(5'b01100, {3'd0,3'd1,3'd1,3'd0,3'd0}, {2'b00,2'b11,2'b00,2'b00,2'b00}, 5'b00010);
      #1;
      chk($sformatf("A full%0d grant", c), 64'(out_grant[5 +: 5]), 64'd0);
      chk($sformatf("A full%0d ready", c), 64'(in_ready), 64'b10011);
      @(posedge clk); #1;
      chk($sformatf("A full%0d valid", c), 64'(out_valid[1]), 64'd1);
      chk($sformatf("A full%0d data", c), 64'(out_data[40 +: 40]), 64'(flit(2, 100, 2'b01)));
    end
    @(negedge clk); seq = 103;
    drive(5'b01100, {3'd0,3'd1,3'd1,3'd0,3'd0}, {2'b00,2'b11,2'b00,2'b00,2'b00}, 5'b0);
    #1;
    chk("A body grant", 64'(out_grant[5 +: 5]), 64'b00100);
    chk("A body ready", 64'(in_ready), 64'b10111);
    @(posedge clk); #1;
    chk("A body data", 64'(out_data[40 +: 40]), 64'(flit(2, 103, 2'b00)));
    @(negedge clk); seq = 104;
    drive(5'b01100, {3'd0,3'd1,3'd1,3'd0,3'd0}, {2'b00,2'b11,2'b10,2'b00,2'b00}, 5'b0);
    #1;
    chk("A tail grant", 64'(out_grant[5 +: 5]), 64'b00100);
    @(posedge clk); #1;
    chk("A tail data", 64'(out_data[40 +: 40]), 64'(flit(2, 104, 2'b10)));
    @(negedge clk); seq = 105;
    drive(5'b01000, {3'd0,3'd1,3'd0,3'd0,3'd0}, {2'b00,2'b11,2'b00,2'b00,2'b00}, 5'b0);
    #1;
    chk("A after grant", 64'(out_grant[5 +: 5]), 64'b01000);
    chk("A after ready", 64'(in_ready), 64'b11111);
    @(posedge clk); #1;
    chk("A after data", 64'(out_data[40 +: 40]), 64'(flit(3, 105, 2'b11)));
    // malformed multi-hot request
    @(negedge clk); seq = 200;
    drive(5'b00001, '0, 10'h3FF, 5'b0);
    in_req[4:0] = 5'b00110;
    #1;
    chk("B grant", 64'(out_grant), 64'd0);
    chk("B ready", 64'(in_ready), 64'b11110);
    chk("B err before", 64'(req_err), 64'd0);
    @(posedge clk); #1;
    chk("B err set", 64'(req_err), 64'd1);
    chk("B out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    drive(5'b0, '0, '0, 5'b0);
    @(posedge clk); #1;
    chk("B err sticky", 64'(req_err), 64'd1);
    reset_pulse("B");
    // reset mid-packet drops the lock
    @(negedge clk); seq = 300;
    drive(5'b00100, {3'd0,3'd0,3'd1,3'd0,3'd0}, {2'b00,2'b00,2'b01,2'b00,2'b00}, 5'b0);
    #1;
    chk("C head grant", 64'(out_grant[5 +: 5]), 64'b00100);
    @(posedge clk); #1;
    chk("C head valid", 64'(out_valid[1]), 64'd1);
    @(negedge clk); seq = 301;
    drive(5'b00100, {3'd0,3'd0,3'd1,3'd0,3'd0}, {2'b00,2'b00,2'b00,2'b00,2'b00}, 5'b0);
    rst = 1'b1;
    #1;
    chk("C rst out_valid", 64'(out_valid), 64'd0);
    chk("C rst out_data", 64'(|out_data), 64'd0);
    chk("C rst req_err", 64'(req_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seq = 302;
    drive(5'b01101, {3'd0,3'd1,3'd1,3'd0,3'd1}, {2'b00,2'b11,2'b00,2'b00,2'b11}, 5'b0);
    #1;
    chk("C post grant", 64'(out_grant[5 +: 5]), 64'b00001);
    chk("C post ready", 64'(in_ready), 64'b10011);
    @(posedge clk); #1;
    chk("C post data", 64'(out_data[40 +: 40]), 64'(flit(0, 302, 2'b11)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
